// File: rtl/knight_pkg.sv
// Shared constants and types for the knight-tour command path: headings,
// opcodes, UART response bytes and the tour sequencer state encoding.
package knight_pkg;

  localparam logic [7:0] HEAD_N = 8'h00;
  localparam logic [7:0] HEAD_W = 8'h3F;
  localparam logic [7:0] HEAD_S = 8'h7F;
  localparam logic [7:0] HEAD_E = 8'hBF;

  localparam logic [3:0] OP_MOVE    = 4'b0010;
  localparam logic [3:0] OP_FANFARE = 4'b0011;

  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_ACK  = 8'h5A;

  typedef enum logic [2:0] {
    IDLE,
    VERT,
    HOLDV,
    HORZ,
    HOLDH
  } tour_state_t;

endpackage

// File: rtl/tour_cmd_seq_if.sv
// Bundle of solver, UART-wrapper and command-processor signals seen by the
// tour sequencer; master is the sequencer side, slave the environment side.
interface tour_cmd_seq_if;

  logic        start_tour;
  logic [4:0]  mv_indx;
  logic [7:0]  move;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  modport master (
    input  start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    output mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp
  );

  modport slave (
    output start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    input  mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp
  );

endinterface

// File: rtl/knight_move_decode.sv
// Splits a one-hot knight move into a vertical leg and a horizontal leg.
// Anything that is not exactly one-hot decodes to heading N, zero squares.
module knight_move_decode
  import knight_pkg::*;
(
    input  logic [7:0] i_move,
    output logic [7:0] o_vert_head,
    output logic [3:0] o_vert_sq,
    output logic [7:0] o_horz_head,
    output logic [3:0] o_horz_sq
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        o_vert_head = HEAD_N;
        o_vert_sq   = 4'd0;
        o_horz_head = HEAD_N;
        o_horz_sq   = 4'd0;
        case (i_move)
            8'h01: begin o_vert_head = HEAD_N; o_vert_sq = 4'd2; o_horz_head = HEAD_E; o_horz_sq = 4'd1; end
            8'h02: begin o_vert_head = HEAD_N; o_vert_sq = 4'd2; o_horz_head = HEAD_W; o_horz_sq = 4'd1; end
            8'h04: begin o_vert_head = HEAD_N; o_vert_sq = 4'd1; o_horz_head = HEAD_W; o_horz_sq = 4'd2; end
            8'h08: begin o_vert_head = HEAD_S; o_vert_sq = 4'd1; o_horz_head = HEAD_W; o_horz_sq = 4'd2; end
            8'h10: begin o_vert_head = HEAD_S; o_vert_sq = 4'd2; o_horz_head = HEAD_W; o_horz_sq = 4'd1; end
            8'h20: begin o_vert_head = HEAD_S; o_vert_sq = 4'd2; o_horz_head = HEAD_E; o_horz_sq = 4'd1; end
            8'h40: begin o_vert_head = HEAD_S; o_vert_sq = 4'd1; o_horz_head = HEAD_E; o_horz_sq = 4'd2; end
            8'h80: begin o_vert_head = HEAD_N; o_vert_sq = 4'd1; o_horz_head = HEAD_E; o_horz_sq = 4'd2; end
            default: ;
        endcase
    end

endmodule

// File: rtl/tour_cmd_seq.sv
// Replays the solver's knight moves as vertical/horizontal motion commands to
// the command processor; passes UART commands straight through when idle.
module tour_cmd_seq
  import knight_pkg::*;
#(
    parameter int NUM_MOVES = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    tour_cmd_seq_if.master bus
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

    tour_state_t r_state;
    logic [4:0]  r_mv_indx;
    logic        r_tour_rdy;
    logic [7:0]  r_move;

    logic [7:0]  w_vert_head;
    logic [3:0]  w_vert_sq;
    logic [7:0]  w_horz_head;
    logic [3:0]  w_horz_sq;
    logic [15:0] w_cmd;
    logic        w_cmd_rdy;
    logic        w_clr_uart;
    logic [7:0]  w_resp;

    knight_move_decode u_decode (
        .i_move      (r_move),
        .o_vert_head (w_vert_head),
        .o_vert_sq   (w_vert_sq),
        .o_horz_head (w_horz_head),
        .o_horz_sq   (w_horz_sq)
    );

    // The move is latched on the first VERT clock, once mv_indx already points
    // at the new move, so cmd never has a combinational path from the solver.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_mv_indx  <= 5'd0;
            r_tour_rdy <= 1'b0;
            r_move     <= 8'h00;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // branch sees the pre-edge values regardless of statement order.
            case (r_state)
                IDLE: begin
                    if (bus.start_tour) begin
                        r_mv_indx <= 5'd0;
                        r_state   <= VERT;
                    end
                end
                VERT: begin
                    if (bus.clr_cmd_rdy) begin
                        r_tour_rdy <= 1'b0;
                        r_state    <= HOLDV;
                    end else if (!r_tour_rdy) begin
                        r_tour_rdy <= 1'b1;
                        r_move     <= bus.move;
                    end
                end
                HOLDV: begin
                    if (bus.send_resp) r_state <= HORZ;
                end
                HORZ: begin
                    if (bus.clr_cmd_rdy) begin
                        r_tour_rdy <= 1'b0;
                        r_state    <= HOLDH;
                    end else if (!r_tour_rdy) begin
                        r_tour_rdy <= 1'b1;
                    end
                end
                HOLDH: begin
                    if (bus.send_resp) begin
                        if (r_mv_indx == LAST_IDX) begin
                            r_mv_indx <= 5'd0;
                            r_state   <= IDLE;
                        end else begin
                            r_mv_indx <= r_mv_indx + 5'd1;
                            r_state   <= VERT;
                        end
                    end
                end
                default: begin
                    r_tour_rdy <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_cmd      = bus.cmd_UART;
        w_cmd_rdy  = bus.cmd_rdy_UART;
        w_clr_uart = bus.clr_cmd_rdy;
        w_resp     = RESP_DONE;
        case (r_state)
            VERT, HOLDV: w_cmd = {OP_MOVE, w_vert_head, w_vert_sq};
            HORZ, HOLDH: w_cmd = {OP_FANFARE, w_horz_head, w_horz_sq};
            default: ;
        endcase
        // In tour mode the UART request is left pending in the wrapper.
        if (r_state != IDLE) begin
            w_cmd_rdy  = r_tour_rdy;
            w_clr_uart = 1'b0;
            w_resp     = (r_state == HOLDH && r_mv_indx == LAST_IDX) ? RESP_DONE : RESP_ACK;
        end
    end

    assign bus.cmd              = w_cmd;
    assign bus.cmd_rdy          = w_cmd_rdy;
    assign bus.clr_cmd_rdy_UART = w_clr_uart;
    assign bus.resp             = w_resp;
    assign bus.mv_indx          = r_mv_indx;

endmodule

// File: doc/tour_cmd_seq.md
Name: tour_cmd_seq

Overview:
- Sequencer between the tour solver and the command processor.
- After the solver signals completion, it walks move indices 0..NUM_MOVES-1 and reads each one-hot knight move.
- Each move is split into two motion commands: a vertical leg, then a horizontal leg.
- It issues those commands with a ready/clear handshake and waits for completion on each.
- When idle it passes UART-sourced commands straight through to the command processor.

Parameters:
- NUM_MOVES, 24, number of solver moves to replay; mv_indx counts 0..NUM_MOVES-1.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- start_tour, input, 1, 1-clk pulse from the solver's done.
- mv_indx, output, 5, index of the move being read from the solver.
- move, input, 8, one-hot move addressed by mv_indx.
- cmd_UART, input, 16, command from the UART wrapper.
- cmd_rdy_UART, input, 1, UART command valid.
- clr_cmd_rdy_UART, output, 1, acknowledge to the UART wrapper.
- cmd, output, 16, command to the command processor: {opcode[15:12], heading[11:4], squares[3:0]}.
- cmd_rdy, output, 1, command valid to the command processor.
- clr_cmd_rdy, input, 1, command processor has consumed cmd.
- send_resp, input, 1, 1-clk pulse: current command finished.
- resp, output, 8, response byte to the UART.

Behaviour:
- Reset values: state IDLE, mv_indx=0, internal tour_rdy=0.
- State set: IDLE, VERT, HOLDV, HORZ, HOLDH.

IDLE (passthrough):
- cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy, resp=8'hA5.
- start_tour: clear mv_indx to 0 and go to VERT next clock.

VERT:
- Drive cmd = {4'b0010, vertical heading, vertical squares}.
- Set tour_rdy on the entry clock; tour_rdy stays set until clr_cmd_rdy, then clears.
- On clr_cmd_rdy, go to HOLDV.

HOLDV:
- Wait for send_resp, then go to HORZ.

HORZ:
- Drive cmd = {4'b0011, horizontal heading, horizontal squares}; opcode 0011 means move with fanfare.
- Same tour_rdy handshake as VERT; on clr_cmd_rdy, go to HOLDH.

HOLDH, on send_resp:
- If mv_indx==NUM_MOVES-1: go to IDLE and reset mv_indx to 0.
- Otherwise: increment mv_indx and go to VERT.

Tour-mode outputs (all states except IDLE):
- cmd_rdy=tour_rdy.
- clr_cmd_rdy_UART=0.
- cmd_rdy_UART is ignored and left pending in the wrapper.
- resp=8'h5A, except resp=8'hA5 while in HOLDH with mv_indx==NUM_MOVES-1 (final response).

Move decode: move is registered at VERT entry, so no comb path from move to cmd. Vertical leg listed first, then horizontal.
- bit0: N2, E1
- bit1: N2, W1
- bit2: N1, W2
- bit3: S1, W2
- bit4: S2, W1
- bit5: S2, E1
- bit6: S1, E2
- bit7: N1, E2

Encodings:
- Headings: N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
- squares is zero-extended to 4 bits.
- A non-one-hot move (including 0) gives heading N, squares 0 on both legs; the handshake still completes.

Boundaries:
- start_tour while not in IDLE: ignored.
- clr_cmd_rdy and send_resp in the same clock in VERT or HORZ: take clr_cmd_rdy only; send_resp is honored only in the HOLD states.
- send_resp in VERT or HORZ: ignored.
- Async reset mid-tour returns to IDLE with tour_rdy=0 and mv_indx=0; the passthrough path is active immediately.
- mv_indx never exceeds NUM_MOVES-1.

Decomposition:
- Shared package (knight_pkg):
  - heading constants HEAD_N/HEAD_W/HEAD_S/HEAD_E;
  - opcodes OP_MOVE=4'b0010, OP_FANFARE=4'b0011;
  - resp constants RESP_DONE=8'hA5, RESP_ACK=8'h5A;
  - tour_state_t enum.
- One natural sub-module, knight_move_decode: combinational one-hot move -> {vert_head, vert_sq, horz_head, horz_sq}.

Test Plan:
- IDLE passthrough: cmd_UART=16'h2003, cmd_rdy_UART=1; pulse clr_cmd_rdy -> cmd=16'h2003, cmd_rdy=1, clr_cmd_rdy_UART pulses the same clock, resp=8'hA5.
- Single move: start_tour, move=8'h01 -> cmd=16'h2002 (N,2); after clr_cmd_rdy and send_resp -> cmd=16'h3BF1 (E,1) with resp=8'h5A; after send_resp, mv_indx=1.
- Full tour with solver model over 24 moves -> exactly 48 cmd_rdy assertions; mv_indx runs 0..23; resp=8'hA5 on the final send_resp; returns to IDLE.
- move=8'h08 -> legs 16'h27F1 then 16'h33F2; move=8'h40 -> 16'h27F1 then 16'h3BF2.
- Reset asserted in HOLDV mid-tour -> next clock IDLE, cmd_rdy follows cmd_rdy_UART, mv_indx=0.
- start_tour pulsed during HORZ and cmd_rdy_UART held high -> no restart, clr_cmd_rdy_UART stays 0, tour completes normally.
